// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
interface if_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Fetch stage: credit-limited imem requests, in-order response FIFO with PCs,
// IF/ID pipeline register with stall and branch redirect (stale responses dropped).
module if_fetch_unit #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  if_fetch_unit_if.master imem,
  input  logic            stall,
  input  logic            ex_take_branch,
  input  logic [31:0]     ex_target_pc,
  output logic [31:0]     if_id_IR,
  output logic [31:0]     if_id_PC,
  output logic            if_id_valid_inst
);
  localparam int unsigned   AW      = $clog2(DEPTH);
  localparam int unsigned   CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d;
  logic [31:0]   fifo_ir_q [DEPTH];
  logic [31:0]   fifo_ir_d [DEPTH];
  logic [31:0]   fifo_pc_q [DEPTH];
  logic [31:0]   fifo_pc_d [DEPTH];
  logic [CW-1:0] fifo_wp_q, fifo_wp_d, fifo_rp_q, fifo_rp_d;
  logic [31:0]   pend_q [DEPTH];
  logic [31:0]   pend_d [DEPTH];
  logic [CW-1:0] pend_wp_q, pend_wp_d, pend_rp_q, pend_rp_d;
  logic [31:0]   ir_q, ir_d, pc_q, pc_d;
  logic          valid_q, valid_d;

  logic [CW-1:0] occ_s;
  logic [CW:0]   credit_s;
  logic          empty_s, full_s, req_valid_s, fire_s, resp_s, push_s, pop_s;

  assign occ_s       = fifo_wp_q - fifo_rp_q;
  assign empty_s     = (occ_s == {CW{1'b0}});
  assign full_s      = (occ_s == DEPTH_C);
  assign credit_s    = {1'b0, out_q} + {1'b0, occ_s};
  assign req_valid_s = !rst && !ex_take_branch && (credit_s < {1'b0, DEPTH_C});
  assign fire_s      = req_valid_s && imem.imem_req_ready;
  // Responses with nothing outstanding are stray and ignored.
  assign resp_s      = imem.imem_resp_valid && (out_q != {CW{1'b0}});

  // Next-state for fetch PC, credit counters, queues and the IF/ID register.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    out_d      = out_q;
    drop_d     = drop_q;
    fifo_ir_d  = fifo_ir_q;
    fifo_pc_d  = fifo_pc_q;
    fifo_wp_d  = fifo_wp_q;
    fifo_rp_d  = fifo_rp_q;
    pend_d     = pend_q;
    pend_wp_d  = pend_wp_q;
    pend_rp_d  = pend_rp_q;
    ir_d       = ir_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    push_s     = 1'b0;
    pop_s      = 1'b0;

    if (fire_s && !resp_s) begin
      out_d = out_q + CW'(1);
    end else if (!fire_s && resp_s) begin
      out_d = out_q - CW'(1);
    end else begin
      out_d = out_q;
    end

    if (ex_take_branch) begin
      fetch_pc_d = ex_target_pc & 32'hFFFF_FFFC;
      fifo_rp_d  = fifo_wp_q;
      pend_rp_d  = pend_wp_q;
      // Everything still in flight after this cycle's response belongs to the old path.
      drop_d     = resp_s ? (out_q - CW'(1)) : out_q;
      valid_d    = 1'b0;
      ir_d       = NOP;
    end else begin
      if (fire_s) begin
        fetch_pc_d                  = fetch_pc_q + 32'd4;
        pend_d[pend_wp_q[AW-1:0]]   = fetch_pc_q;
        pend_wp_d                   = pend_wp_q + CW'(1);
      end else begin
        fetch_pc_d = fetch_pc_q;
      end

      if (resp_s) begin
        if (drop_q != {CW{1'b0}}) begin
          drop_d = drop_q - CW'(1);
        end else begin
          push_s                       = 1'b1;
          fifo_ir_d[fifo_wp_q[AW-1:0]] = imem.imem_resp_data;
          fifo_pc_d[fifo_wp_q[AW-1:0]] = pend_q[pend_rp_q[AW-1:0]];
          fifo_wp_d                    = fifo_wp_q + CW'(1);
          pend_rp_d                    = pend_rp_q + CW'(1);
        end
      end else begin
        drop_d = drop_q;
      end

      if (stall) begin
        valid_d = valid_q;
      end else if (!empty_s) begin
        pop_s     = 1'b1;
        ir_d      = fifo_ir_q[fifo_rp_q[AW-1:0]];
        pc_d      = fifo_pc_q[fifo_rp_q[AW-1:0]];
        valid_d   = 1'b1;
        fifo_rp_d = fifo_rp_q + CW'(1);
      end else begin
        valid_d = 1'b0;
        ir_d    = NOP;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      out_q      <= {CW{1'b0}};
      drop_q     <= {CW{1'b0}};
      fifo_ir_q  <= '{default: 32'h0000_0000};
      fifo_pc_q  <= '{default: 32'h0000_0000};
      fifo_wp_q  <= {CW{1'b0}};
      fifo_rp_q  <= {CW{1'b0}};
      pend_q     <= '{default: 32'h0000_0000};
      pend_wp_q  <= {CW{1'b0}};
      pend_rp_q  <= {CW{1'b0}};
      ir_q       <= NOP;
      pc_q       <= 32'h0000_0000;
      valid_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      fifo_ir_q  <= fifo_ir_d;
      fifo_pc_q  <= fifo_pc_d;
      fifo_wp_q  <= fifo_wp_d;
      fifo_rp_q  <= fifo_rp_d;
      pend_q     <= pend_d;
      pend_wp_q  <= pend_wp_d;
      pend_rp_q  <= pend_rp_d;
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
    end
  end

  assign imem.imem_req_valid = req_valid_s;
  assign imem.imem_addr      = fetch_pc_q;
  assign if_id_IR            = ir_q;
  assign if_id_PC            = pc_q;
  assign if_id_valid_inst    = valid_q;

  if_fetch_unit_chk #(.CW(CW), .DEPTH(DEPTH)) u_chk (
    .clk      (clk),
    .rst      (rst),
    .push_i   (push_s),
    .pop_i    (pop_s),
    .full_i   (full_s),
    .credit_i (credit_s)
  );
endmodule

// Protocol invariants of the fetch queue.
module if_fetch_unit_chk #(
  parameter int unsigned CW    = 2,
  parameter int unsigned DEPTH = 2
) (
  input logic        clk,
  input logic        rst,
  input logic        push_i,
  input logic        pop_i,
  input logic        full_i,
  input logic [CW:0] credit_i
);
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push_i && full_i && !pop_i));
  a_credit_bound: assert property (@(posedge clk) disable iff (rst) credit_i <= (CW+1)'(DEPTH));
endmodule
